// File: rtl/Stark_pkg.sv
// Shared core types for the integer multiply unit: ROB index and flush mask,
// physical register number, memory/lane size and multiply opcode.
// No ports; imported by stark_imul_lanes and stark_imul_lane.
package Stark_pkg;

    localparam int ROB_ENTRIES = 32;

    typedef logic [4:0]             rob_ndx_t;
    typedef logic [ROB_ENTRIES-1:0] rob_bitmask_t;
    typedef logic [7:0]             pregno_t;

    // Lane size; the encoding is log2(lane bytes), which the lane selector relies on.
    typedef enum logic [2:0] {
        SZ_BYTE  = 3'd0,
        SZ_WYDE  = 3'd1,
        SZ_TETRA = 3'd2,
        SZ_OCTA  = 3'd3,
        SZ_HEXI  = 3'd4
    } memsz_t;

    typedef enum logic [2:0] {
        IMUL_MUL   = 3'd0,
        IMUL_MULH  = 3'd1,
        IMUL_MULHU = 3'd2,
        IMUL_MULSU = 3'd3,
        IMUL_MULA  = 3'd4
    } imul_op_t;

endpackage

// File: rtl/stark_imul_lane.sv
// One L-bit multiply lane: low/high product or multiply-add, result delayed DEPTH-1 clocks.
// Ports: clk, rst, op (issue-cycle opcode), a/b/c operands, res (aligned with conveyor stage DEPTH-1).
// No backpressure: a new operand set is accepted every cycle; validity is tracked by the parent.
module stark_imul_lane
    import Stark_pkg::*;
#(
    parameter int L     = 64,
    parameter int DEPTH = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  imul_op_t     op,
    input  logic [L-1:0] a,
    input  logic [L-1:0] b,
    input  logic [L-1:0] c,
    output logic [L-1:0] res
);

    logic           a_sx;
    logic           b_sx;
    logic [2*L-1:0] ax;
    logic [2*L-1:0] bx;
    logic [2*L-1:0] prod;
    logic [L-1:0]   res_c;

    // A 2L-bit product of the sign/zero-extended operands, taken modulo 2^2L,
    // yields correct high halves for every signedness combination.
    always_comb begin
        a_sx = (op == IMUL_MULH) || (op == IMUL_MULSU);
        b_sx = (op == IMUL_MULH);
        ax   = {{L{a_sx & a[L-1]}}, a};
        bx   = {{L{b_sx & b[L-1]}}, b};
        prod = ax * bx;
        case (op)
            IMUL_MUL:  res_c = prod[L-1:0];
            IMUL_MULA: res_c = prod[L-1:0] + c;
            default:   res_c = prod[2*L-1:L];
        endcase
    end

    logic [L-1:0] pipe [1:DEPTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 1; s < DEPTH; s++) pipe[s] <= '0;
        end else begin
            pipe[1] <= res_c;
            for (int s = 2; s < DEPTH; s++) pipe[s] <= pipe[s-1];
        end
    end

    assign res = pipe[DEPTH-1];

endmodule

// File: rtl/stark_imul_lanes.sv
// SIMD integer multiplier: per-lane MUL/MULH/MULHU/MULSU/MULA with byte copy/zero merge.
// Ports: issue side (valid_i, rndx_i, op_i, prc_i, a/b/c/t, cptgt_i, z_i, pRd_i), stomp flush mask,
// completion side (valid_o, rndx_o, pRd_o, o, we_o). Fixed DEPTH-cycle latency, no backpressure.
module stark_imul_lanes
    import Stark_pkg::*;
#(
    parameter int WID          = 64,
    parameter int DEPTH        = 3,
    parameter int SUPPORT_PREC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  rob_bitmask_t     stomp,
    input  logic             valid_i,
    input  rob_ndx_t         rndx_i,
    input  imul_op_t         op_i,
    input  memsz_t           prc_i,
    input  logic [WID-1:0]   a_i,
    input  logic [WID-1:0]   b_i,
    input  logic [WID-1:0]   c_i,
    input  logic [WID-1:0]   t_i,
    input  logic [WID/8-1:0] cptgt_i,
    input  logic             z_i,
    input  pregno_t          pRd_i,
    output logic             valid_o,
    output rob_ndx_t         rndx_o,
    output pregno_t          pRd_o,
    output logic [WID-1:0]   o,
    output logic [WID/8-1:0] we_o
);

    localparam int NB     = WID / 8;
    localparam int FULL_G = (WID == 128) ? 4 : 3;   // size index of a full-width lane

    typedef struct packed {
        logic            vld;
        imul_op_t        op;
        memsz_t          prc;
        rob_ndx_t        rndx;
        pregno_t         prd;
        logic [WID-1:0]  t;
        logic [NB-1:0]   cptgt;
        logic            z;
    } ctl_t;

    // Hexi on a 64-bit path, or any size without sub-word support, collapses to one full lane.
    function automatic int sz_idx(input memsz_t p);
        if (SUPPORT_PREC == 0)  return FULL_G;
        if (int'(p) > FULL_G)   return FULL_G;
        return int'(p);
    endfunction

    // Every lane size computes in parallel; the size travelling with the op picks one at the end.
    logic [4:0][WID-1:0] res;

    for (genvar g = 0; g < 5; g++) begin : g_sz
        localparam int L = 8 << g;
        if (L <= WID && (SUPPORT_PREC != 0 || L == WID)) begin : g_on
            for (genvar i = 0; i < WID / L; i++) begin : g_lane
                stark_imul_lane #(.L(L), .DEPTH(DEPTH)) u_lane (
                    .clk (clk),
                    .rst (rst),
                    .op  (op_i),
                    .a   (a_i[i*L +: L]),
                    .b   (b_i[i*L +: L]),
                    .c   (c_i[i*L +: L]),
                    .res (res[g][i*L +: L])
                );
            end
        end else begin : g_off
            assign res[g] = '0;
        end
    end

    ctl_t issue;
    ctl_t stg [1:DEPTH-1];

    always_comb begin
        issue       = '0;
        issue.vld   = valid_i & ~stomp[rndx_i];
        issue.op    = op_i;
        issue.prc   = prc_i;
        issue.rndx  = rndx_i;
        issue.prd   = pRd_i;
        issue.t     = t_i;
        issue.cptgt = cptgt_i;
        issue.z     = z_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 1; s < DEPTH; s++) stg[s] <= '0;
        end else begin
            stg[1] <= issue;
            for (int s = 2; s < DEPTH; s++) begin
                stg[s]     <= stg[s-1];
                stg[s].vld <= stg[s-1].vld & ~stomp[stg[s-1].rndx];
            end
        end
    end

    ctl_t           last;
    logic           done;
    logic [WID-1:0] prod;
    logic [WID-1:0] merged;

    always_comb begin
        last   = stg[DEPTH-1];
        done   = last.vld & ~stomp[last.rndx];
        prod   = res[sz_idx(last.prc)];
        merged = prod;
        for (int k = 0; k < NB; k++) begin
            if (last.cptgt[k]) merged[k*8 +: 8] = last.z ? 8'h00 : last.t[k*8 +: 8];
        end
    end

    // Result fields hold their value between completions so o stays 0 after reset until one arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o <= 1'b0;
            we_o    <= '0;
            o       <= '0;
            rndx_o  <= '0;
            pRd_o   <= '0;
        end else begin
            valid_o <= done;
            we_o    <= (done && last.prd != '0) ? '1 : '0;
            if (done) begin
                o      <= merged;
                rndx_o <= last.rndx;
                pRd_o  <= last.prd;
            end
        end
    end

    // The opcode rides along for completeness; the lanes already consumed it at issue.
    logic unused_op;
    assign unused_op = ^last.op;

endmodule

// File: tb/tb_stark_imul_lanes.sv
// Bench for stark_imul_lanes (WID=64, DEPTH=3): directed vector table, stomp and reset sequences,
// then randomized traffic checked against an arithmetic per-lane model and a completion-cycle scoreboard.
module tb_stark_imul_lanes;
    import Stark_pkg::*;

    localparam int WID   = 64;
    localparam int DEPTH = 3;

    logic         clk = 1'b0;
    logic         rst;
    rob_bitmask_t stomp;
    logic         valid_i;
    rob_ndx_t     rndx_i;
    imul_op_t     op_i;
    memsz_t       prc_i;
    logic [63:0]  a_i, b_i, c_i, t_i;
    logic [7:0]   cptgt_i;
    logic         z_i;
    pregno_t      pRd_i;
    logic         valid_o;
    rob_ndx_t     rndx_o;
    pregno_t      pRd_o;
    logic [63:0]  o;
    logic [7:0]   we_o;

    always #5 clk = ~clk;

    stark_imul_lanes #(.WID(WID), .DEPTH(DEPTH), .SUPPORT_PREC(1)) dut (
        .clk(clk), .rst(rst), .stomp(stomp), .valid_i(valid_i), .rndx_i(rndx_i),
        .op_i(op_i), .prc_i(prc_i), .a_i(a_i), .b_i(b_i), .c_i(c_i), .t_i(t_i),
        .cptgt_i(cptgt_i), .z_i(z_i), .pRd_i(pRd_i), .valid_o(valid_o),
        .rndx_o(rndx_o), .pRd_o(pRd_o), .o(o), .we_o(we_o)
    );

    typedef struct {
        logic [63:0] o;
        rob_ndx_t    rndx;
        pregno_t     prd;
    } exp_t;

    typedef struct {
        imul_op_t    op;
        memsz_t      prc;
        logic [63:0] a, b, c, t;
        logic [7:0]  cm;
        bit          z;
        pregno_t     prd;
        logic [63:0] exp;
    } vec_t;

    exp_t     pend [int];     // expected completions keyed by the cycle they must appear
    int       cyc;
    int       checks;
    int       failures;
    rob_ndx_t rndx_ctr;
    rob_ndx_t last_rndx;
    vec_t     tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Lane results from plain wide arithmetic: signed views are formed by subtracting 2^L.
    function automatic logic [63:0] model(input imul_op_t op, input memsz_t prc,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c, input logic [63:0] t,
                                          input logic [7:0] cm, input bit z);
        int L;
        logic [255:0] mask, ua, ub, uc, p;
        logic [63:0] r;
        L    = (prc == SZ_HEXI) ? 64 : (8 << int'(prc));
        mask = (256'd1 << L) - 256'd1;
        r    = '0;
        for (int i = 0; i < 64 / L; i++) begin
            ua = (256'(a) >> (i * L)) & mask;
            ub = (256'(b) >> (i * L)) & mask;
            uc = (256'(c) >> (i * L)) & mask;
            if ((op == IMUL_MULH || op == IMUL_MULSU) && ua[L-1]) ua = ua - (256'd1 << L);
            if (op == IMUL_MULH && ub[L-1]) ub = ub - (256'd1 << L);
            p = ua * ub;
            if (op == IMUL_MULA) p = p + uc;
            if (op != IMUL_MUL && op != IMUL_MULA) p = p >> L;
            p = p & mask;
            r = r | 64'(p << (i * L));
        end
        for (int k = 0; k < 8; k++) begin
            if (cm[k]) r[k*8 +: 8] = z ? 8'h00 : t[k*8 +: 8];
        end
        return r;
    endfunction

    task automatic check_outputs();
        exp_t e;
        if (pend.exists(cyc)) begin
            e = pend[cyc];
            chk("valid_o", 64'(valid_o), 64'd1);
            chk("o", o, e.o);
            chk("rndx_o", 64'(rndx_o), 64'(e.rndx));
            chk("pRd_o", 64'(pRd_o), 64'(e.prd));
            chk("we_o", 64'(we_o), (e.prd != 0) ? 64'hFF : 64'h00);
            pend.delete(cyc);
        end else begin
            chk("idle_valid_o", 64'(valid_o), 64'd0);
            chk("idle_we_o", 64'(we_o), 64'd0);
        end
    endtask

    // Check this cycle's outputs, drive this cycle's inputs, update expectations, advance one clock.
    task automatic step(input bit v, input imul_op_t op, input memsz_t prc,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic [63:0] t, input logic [7:0] cm, input bit z,
                        input pregno_t prd, input rob_bitmask_t stm);
        exp_t e;
        int   keys [$];
        check_outputs();
        valid_i = v;   rndx_i = rndx_ctr; op_i = op;  prc_i = prc;
        a_i = a; b_i = b; c_i = c; t_i = t;
        cptgt_i = cm;  z_i = z; pRd_i = prd; stomp = stm;
        if (v) begin
            e.o = model(op, prc, a, b, c, t, cm, z);
            e.rndx = rndx_ctr;
            e.prd = prd;
            pend[cyc + DEPTH] = e;
            last_rndx = rndx_ctr;
            rndx_ctr++;
        end
        foreach (pend[k]) if (k > cyc && stm[pend[k].rndx]) keys.push_back(k);
        foreach (keys[j]) pend.delete(keys[j]);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, IMUL_MUL, SZ_OCTA, '0, '0, '0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic issue(input imul_op_t op, input memsz_t prc, input logic [63:0] a,
                         input logic [63:0] b, input pregno_t prd, input rob_bitmask_t stm);
        step(1'b1, op, prc, a, b, 64'd0, 64'd0, 8'h00, 1'b0, prd, stm);
    endtask

    initial begin
        rob_ndx_t    op1_rndx;
        rob_bitmask_t stm;
        checks = 0; failures = 0; cyc = 0; rndx_ctr = '0; last_rndx = '0;

        tbl[0] = '{IMUL_MUL,   SZ_OCTA,  64'd7, 64'd6, 64'd0, 64'd0, 8'h00, 1'b0, 8'd5, 64'd42};
        tbl[1] = '{IMUL_MULH,  SZ_OCTA,  '1, '1, 64'd0, 64'd0, 8'h00, 1'b0, 8'd6, 64'd0};
        tbl[2] = '{IMUL_MULHU, SZ_OCTA,  '1, '1, 64'd0, 64'd0, 8'h00, 1'b0, 8'd7, 64'hFFFFFFFFFFFFFFFE};
        tbl[3] = '{IMUL_MUL,   SZ_WYDE,  64'h0002000300040005, 64'h0003000300030003, 64'd0, 64'd0,
                   8'h00, 1'b0, 8'd8, 64'h00060009000C000F};
        tbl[4] = '{IMUL_MULA,  SZ_OCTA,  64'd2, 64'd3, 64'd4, 64'h1111111111111111, 8'h0F, 1'b1,
                   8'd9, 64'h0};
        tbl[5] = '{IMUL_MULA,  SZ_OCTA,  64'd2, 64'd3, 64'd4, 64'h1111111111111111, 8'h0F, 1'b0,
                   8'd10, 64'h0000000011111111};
        tbl[6] = '{IMUL_MULSU, SZ_BYTE,  '1, '1, 64'd0, 64'd0, 8'h00, 1'b0, 8'd0, 64'hFFFFFFFFFFFFFFFF};
        tbl[7] = '{IMUL_MULHU, SZ_BYTE,  '1, '1, 64'd0, 64'd0, 8'h00, 1'b0, 8'd11, 64'hFEFEFEFEFEFEFEFE};
        tbl[8] = '{IMUL_MUL,   SZ_TETRA, 64'h00000003FFFFFFFF, 64'h0000000500000002, 64'd0, 64'd0,
                   8'h00, 1'b0, 8'd12, 64'h0000000FFFFFFFFE};
        tbl[9] = '{IMUL_MULH,  SZ_TETRA, 64'h8000000080000000, 64'h8000000080000000, 64'd0, 64'd0,
                   8'h00, 1'b0, 8'd13, 64'h4000000040000000};

        // Reset state.
        rst = 1'b1; stomp = '0; valid_i = 1'b0; rndx_i = '0; op_i = IMUL_MUL; prc_i = SZ_OCTA;
        a_i = '0; b_i = '0; c_i = '0; t_i = '0; cptgt_i = '0; z_i = 1'b0; pRd_i = '0;
        #2;
        chk("rst_valid_o", 64'(valid_o), 64'd0);
        chk("rst_we_o", 64'(we_o), 64'd0);
        chk("rst_o", o, 64'd0);
        chk("rst_rndx_o", 64'(rndx_o), 64'd0);
        chk("rst_pRd_o", 64'(pRd_o), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors, each drained separately; the result is checked against the table constant.
        for (int n = 0; n < 10; n++) begin
            step(1'b1, tbl[n].op, tbl[n].prc, tbl[n].a, tbl[n].b, tbl[n].c, tbl[n].t,
                 tbl[n].cm, tbl[n].z, tbl[n].prd, '0);
            for (int d = 1; d < DEPTH; d++) idle();
            chk($sformatf("tbl%0d_valid", n), 64'(valid_o), 64'd1);
            chk($sformatf("tbl%0d_o", n), o, tbl[n].exp);
            idle();
        end

        // Hexi on a 64-bit path behaves as octa.
        issue(IMUL_MUL, SZ_HEXI, 64'd7, 64'd6, 8'd3, '0);
        for (int d = 1; d < DEPTH; d++) idle();
        chk("hexi_o", o, 64'd42);
        idle();

        // Three back-to-back ops; the middle one is stomped while in stage 1.
        issue(IMUL_MUL, SZ_OCTA, 64'd3, 64'd5, 8'd1, '0);
        issue(IMUL_MULHU, SZ_BYTE, '1, 64'h0102030405060708, 8'd2, '0);
        op1_rndx = last_rndx;
        stm = '0;
        stm[op1_rndx] = 1'b1;
        issue(IMUL_MUL, SZ_WYDE, 64'h0002000300040005, 64'h0007000700070007, 8'd3, stm);
        chk("stomp_c3_valid", 64'(valid_o), 64'd1);
        idle();
        chk("stomp_c4_valid", 64'(valid_o), 64'd0);
        chk("stomp_c4_we", 64'(we_o), 64'd0);
        idle();
        chk("stomp_c5_valid", 64'(valid_o), 64'd1);
        for (int d = 0; d < DEPTH; d++) idle();

        // Reset with three ops in flight.
        issue(IMUL_MUL, SZ_OCTA, 64'd9, 64'd9, 8'd4, '0);
        issue(IMUL_MUL, SZ_OCTA, 64'd8, 64'd8, 8'd4, '0);
        issue(IMUL_MUL, SZ_OCTA, 64'd6, 64'd6, 8'd4, '0);
        valid_i = 1'b0; stomp = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid_o", 64'(valid_o), 64'd0);
        chk("rst_mid_we_o", 64'(we_o), 64'd0);
        chk("rst_mid_o", o, 64'd0);
        pend.delete();
        @(posedge clk); #1;
        cyc++;
        rst = 1'b0;
        for (int d = 0; d < DEPTH; d++) begin
            chk("post_rst_o", o, 64'd0);
            idle();
        end

        // Randomized traffic with occasional stomps of in-flight or issuing ops.
        for (int n = 0; n < 400; n++) begin
            bit           v;
            rob_bitmask_t s;
            logic [63:0]  ra, rb, rc, rt;
            v  = ($urandom_range(0, 3) != 0);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = {$urandom, $urandom};
            rt = {$urandom, $urandom};
            s  = '0;
            if ($urandom_range(0, 4) == 0) s[rndx_ctr - rob_ndx_t'($urandom_range(0, DEPTH))] = 1'b1;
            step(v, imul_op_t'(3'($urandom_range(0, 4))), memsz_t'(3'($urandom_range(0, 4))),
                 ra, rb, rc, rt, ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                 1'($urandom), ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom), s);
        end
        for (int d = 0; d <= DEPTH; d++) idle();
        chk("drained", 64'(pend.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stark_imul_lanes.md
STARK_IMUL_LANES -- requirements
Module: stark_imul_lanes

Interface
REQ-001 SHALL have parameter WID, default 64, datapath width in bits; legal values 64 and 128.
REQ-002 SHALL have parameter DEPTH, default 3, pipeline stages from issue to result; legal range 2..6.
REQ-003 SHALL have parameter SUPPORT_PREC, default 1; 0 means full-width lanes only.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port stomp, input, rob_bitmask_t, ROB entries being flushed this cycle.
REQ-007 SHALL have port valid_i, input, 1, issue strobe.
REQ-008 SHALL have port rndx_i, input, rob_ndx_t, ROB index of the issued op.
REQ-009 SHALL have port op_i, input, imul_op_t, one of MUL, MULH, MULHU, MULSU, MULA.
REQ-010 SHALL have port prc_i, input, memsz_t, lane size: byte, wyde, tetra, octa, hexi.
REQ-011 SHALL have ports a_i, b_i, c_i, t_i, each input, WID, multiplicand, multiplier, addend, old target.
REQ-012 SHALL have port cptgt_i, input, WID/8, per-byte copy-target mask.
REQ-013 SHALL have port z_i, input, 1, zero (rather than copy) masked bytes.
REQ-014 SHALL have port pRd_i, input, pregno_t, destination physical register.
REQ-015 SHALL have ports valid_o, output, 1, and rndx_o, output, rob_ndx_t, completing op and its ROB index.
REQ-016 SHALL have port pRd_o, output, pregno_t, destination of the completing op.
REQ-017 SHALL have port o, output, WID, result.
REQ-018 SHALL have port we_o, output, WID/8, per-byte write enable.

Function
REQ-019 SHALL accept one op per cycle with no backpressure; every valid_i is captured.
REQ-020 SHALL present the result of an op issued in cycle N on o/valid_o in cycle N+DEPTH, registered.
REQ-021 SHALL partition a_i/b_i/c_i into WID/L independent lanes, L = 8,16,32,64,128 per prc_i; hexi with WID=64, or any prc_i when SUPPORT_PREC=0, SHALL use L=WID.
REQ-022 SHALL compute per lane: MUL low L bits of a*b; MULH high L bits signed*signed; MULHU high L bits unsigned*unsigned; MULSU high L bits signed a * unsigned b; MULA low L bits of a*b+c.
REQ-023 SHALL carry op, prc, rndx, pRd, t, cptgt, z in a valid-tagged conveyor of DEPTH stages alongside the datapath.
REQ-024 SHALL clear the valid bit of any stage (including the issuing op) whose rndx bit is set in stomp that cycle.
REQ-025 SHALL drive valid_o=1 only for a non-stomped op reaching stage DEPTH; otherwise valid_o=0.
REQ-026 SHALL drive we_o all-ones when valid_o=1 and pRd_o!=0; else all-zeros.
REQ-027 SHALL drive byte k of o as 8'h00 when cptgt[k] and z, as t byte k when cptgt[k] and not z, else product byte k.
REQ-028 SHALL treat back-to-back ops with differing prc/op independently; no stage state leaks between ops.
REQ-029 SHALL leave stages not stomped unaffected when a stomp hits one stage.

Reset
REQ-030 SHALL on rst clear all conveyor valid bits and drive valid_o=0, we_o=0, o=0, rndx_o=0, pRd_o=0 immediately and until the first post-reset completion.
REQ-031 SHALL discard ops in flight at reset; none complete after rst deasserts.

Structure
REQ-032 SHALL take imul_op_t, memsz_t, rob_ndx_t, rob_bitmask_t, pregno_t from Stark_pkg; imul_op_t encoding is added there.
REQ-033 SHALL use one sub-module stark_imul_lane (parametrised lane width, pipelined to DEPTH) instantiated per lane size.
REQ-034 SHALL keep the control conveyor in this module, not inside the lanes.

Verification
REQ-035 WID=64, DEPTH=3: MUL octa a=7, b=6 issued cycle 0 -> cycle 3 valid_o=1, o=42, we_o=8'hFF.
REQ-036 MULH octa a=-1, b=-1 -> o=0; MULHU a=b=64'hFFFFFFFFFFFFFFFF -> o=64'hFFFFFFFFFFFFFFFE.
REQ-037 MUL wyde a=64'h0002_0003_0004_0005, b=all lanes 3 -> o=64'h0006_0009_000C_000F.
REQ-038 Ops in cycles 0,1,2, stomp hits cycle-1 op's rndx in cycle 2 -> completions cycles 3 and 5 only, cycle 4 valid_o=0, we_o=0.
REQ-039 cptgt=8'h0F, z=1, MULA octa a=2,b=3,c=4 -> o low 4 bytes 0, upper bytes product 10's bytes (0); with z=0, t=64'h1111..., low 4 bytes 8'h11.
REQ-040 rst asserted with three ops in flight -> valid_o=0 same cycle, no completion in the 3 cycles after release.
